vga_sync_decoder: RTL and testbench

Receive-side VGA timing decoder. It samples a 640x480@60Hz HS/VS/colour stream, checks the stream against the nominal frame format and locks onto it. Once locked, it recovers per-pixel coordinates and colour. It sits on the far end of the VGA output path as a loopback checker for the snake-game display, and as a capture front end for frame-comparison logic.

---
 rtl/vga_sync_decoder_if.sv | 23 ++
 rtl/vga_sync_decoder.sv | 166 ++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/vga_sync_decoder_if.sv
// Sync/colour stream into the VGA decoder and the recovered pixel stream out of it.
interface vga_sync_decoder_if;
    logic        HS;
    logic        VS;
    logic [11:0] COLOUR_IN;
    logic [9:0]  PIXEL_X;
    logic [9:0]  PIXEL_Y;
    logic [11:0] PIXEL_COLOUR;
    logic        PIXEL_VALID;
    logic        FRAME_START;
    logic        LOCKED;
    logic        TIMING_ERR;

    modport master (
        output HS, VS, COLOUR_IN,
        input  PIXEL_X, PIXEL_Y, PIXEL_COLOUR, PIXEL_VALID, FRAME_START, LOCKED, TIMING_ERR
    );

    modport slave (
        input  HS, VS, COLOUR_IN,
        output PIXEL_X, PIXEL_Y, PIXEL_COLOUR, PIXEL_VALID, FRAME_START, LOCKED, TIMING_ERR
    );
endinterface

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing decoder: verifies HS/VS timing against the nominal format,
// locks after one clean frame and recovers pixel coordinates and colour.
module vga_sync_decoder #(
    parameter int unsigned H_PULSE   = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned V_PULSE   = 2,
    parameter int unsigned V_BACK    = 33,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FRONT   = 10
) (
    input  logic              CLK,
    input  logic              RESET,
    vga_sync_decoder_if.slave vga
);
    localparam int unsigned H_TOTAL = H_PULSE + H_BACK + H_DISPLAY + H_FRONT;
    localparam int unsigned V_TOTAL = V_PULSE + V_BACK + V_DISPLAY + V_FRONT;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC   = 10'(H_PULSE);
    localparam logic [9:0] V_SYNC   = 10'(V_PULSE);
    localparam logic [9:0] H_ACT_LO = 10'(H_PULSE + H_BACK);
    localparam logic [9:0] H_ACT_HI = 10'(H_PULSE + H_BACK + H_DISPLAY);
    localparam logic [9:0] V_ACT_LO = 10'(V_PULSE + V_BACK);
    localparam logic [9:0] V_ACT_HI = 10'(V_PULSE + V_BACK + V_DISPLAY);
    localparam logic [9:0] POS_MAX  = '1;

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_VERIFY,
        ST_LOCKED
    } state_e;

    state_e      state_q, state_d;

    logic        hs_q, vs_q, hs_prev_q, vs_prev_q;
    logic [11:0] colour_q;
    logic [9:0]  h_pos_q, h_pos_d;
    logic [9:0]  v_pos_q, v_pos_d;

    logic        hs_fall, hs_rise, vs_fall, vs_rise;
    logic        violation;
    logic        active;

    logic [9:0]  pixel_x_q, pixel_x_d;
    logic [9:0]  pixel_y_q, pixel_y_d;
    logic [11:0] pixel_colour_q, pixel_colour_d;
    logic        pixel_valid_q, pixel_valid_d;
    logic        frame_start_q, frame_start_d;
    logic        locked_q, locked_d;
    logic        timing_err_q, timing_err_d;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            colour_q  <= '0;
            hs_prev_q <= 1'b0;
            vs_prev_q <= 1'b0;
            h_pos_q   <= '0;
            v_pos_q   <= '0;
        end else begin
            hs_q      <= vga.HS;
            vs_q      <= vga.VS;
            colour_q  <= vga.COLOUR_IN;
            hs_prev_q <= hs_q;
            vs_prev_q <= vs_q;
            h_pos_q   <= h_pos_d;
            v_pos_q   <= v_pos_d;
        end
    end

    // h_pos_d/v_pos_d are the position of the stage-1 sample; *_q hold the previous sample's.
    always_comb begin
        hs_fall = hs_prev_q & ~hs_q;
        hs_rise = ~hs_prev_q & hs_q;
        vs_fall = vs_prev_q & ~vs_q;
        vs_rise = ~vs_prev_q & vs_q;

        h_pos_d = (h_pos_q == POS_MAX) ? POS_MAX : h_pos_q + 10'd1;
        v_pos_d = v_pos_q;
        if (hs_fall) begin
            h_pos_d = '0;
            if (vs_fall) begin
                v_pos_d = '0;
            end else if (v_pos_q != POS_MAX) begin
                v_pos_d = v_pos_q + 10'd1;
            end
        end

        violation = (hs_fall && (h_pos_q != H_LAST))
                 || (!hs_fall && (h_pos_q == H_LAST))
                 || (hs_rise && (h_pos_d != H_SYNC))
                 || ((vs_fall || vs_rise) && !hs_fall)
                 || (vs_rise && (v_pos_d != V_SYNC))
                 || (vs_fall && (v_pos_q != V_LAST));
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= ST_SEARCH;
        end else begin
            state_q <= state_d;
        end
    end

    // A violation outranks a coincident VS falling edge; that edge never starts a new VERIFY.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SEARCH: if (vs_fall) state_d = ST_VERIFY;
            ST_VERIFY: begin
                if (violation) begin
                    state_d = ST_SEARCH;
                end else if (vs_fall) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: if (violation) state_d = ST_SEARCH;
            default:   state_d = ST_SEARCH;
        endcase
    end

    always_comb begin
        active = (h_pos_d >= H_ACT_LO) && (h_pos_d < H_ACT_HI)
              && (v_pos_d >= V_ACT_LO) && (v_pos_d < V_ACT_HI);

        locked_d       = (state_d == ST_LOCKED);
        timing_err_d   = violation && (state_q != ST_SEARCH);
        pixel_valid_d  = locked_d && active;
        frame_start_d  = locked_d && hs_fall && vs_fall;
        pixel_x_d      = pixel_valid_d ? h_pos_d - H_ACT_LO : '0;
        pixel_y_d      = pixel_valid_d ? v_pos_d - V_ACT_LO : '0;
        pixel_colour_d = pixel_valid_d ? colour_q : '0;
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            pixel_x_q      <= '0;
            pixel_y_q      <= '0;
            pixel_colour_q <= '0;
            pixel_valid_q  <= 1'b0;
            frame_start_q  <= 1'b0;
            locked_q       <= 1'b0;
            timing_err_q   <= 1'b0;
        end else begin
            pixel_x_q      <= pixel_x_d;
            pixel_y_q      <= pixel_y_d;
            pixel_colour_q <= pixel_colour_d;
            pixel_valid_q  <= pixel_valid_d;
            frame_start_q  <= frame_start_d;
            locked_q       <= locked_d;
            timing_err_q   <= timing_err_d;
        end
    end

    assign vga.PIXEL_X      = pixel_x_q;
    assign vga.PIXEL_Y      = pixel_y_q;
    assign vga.PIXEL_COLOUR = pixel_colour_q;
    assign vga.PIXEL_VALID  = pixel_valid_q;
    assign vga.FRAME_START  = frame_start_q;
    assign vga.LOCKED       = locked_q;
    assign vga.TIMING_ERR   = timing_err_q;
endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a shrunken frame format: a bench-side timing generator with
// injectable faults drives the decoder, and a lock/coordinate model predicts every output.
module tb_vga_sync_decoder;
    localparam int HP = 4, HB = 3, HD = 8, HF = 2;
    localparam int VP = 2, VB = 2, VD = 5, VF = 2;
    localparam int HT = HP + HB + HD + HF;
    localparam int VT = VP + VB + VD + VF;
    localparam int FRAME = HT * VT;

    typedef struct {
        bit          hs;
        bit          vs;
        logic [11:0] col;
        int          hc;
        int          vc;
        bit          fault;
    } samp_t;

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [11:0] col;
        bit          valid;
        bit          fs;
        bit          locked;
        bit          err;
    } exp_t;

    logic CLK = 1'b0;
    logic RESET = 1'b0;

    vga_sync_decoder_if vga ();

    vga_sync_decoder #(
        .H_PULSE(HP), .H_BACK(HB), .H_DISPLAY(HD), .H_FRONT(HF),
        .V_PULSE(VP), .V_BACK(VB), .V_DISPLAY(VD), .V_FRONT(VF)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .vga  (vga)
    );

    always #5 CLK = ~CLK;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // generator state and one-shot fault targets (line index within the current frame)
    int hc = 0, vc = 0;
    int stretch_v = -1;
    int short_v   = -1;
    bit colour_fff = 1'b0;

    // reference model: a sample pending in the input stage, the sample before it, and
    // the number of clean frame starts since the last reset or counted violation
    samp_t s1, prev;
    int    starts = 0;

    int lock_rise_cyc = -1;
    int valid_cnt = 0;
    bit err_seen = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input bit rst_v);
        samp_t p;
        exp_t  e;
        int    hsw, line_len;
        bit    hs_fall, vs_fall;

        hsw     = (vc == short_v) ? HP - 1 : HP;
        p.hc    = hc;
        p.vc    = vc;
        p.hs    = !(hc < hsw);
        p.vs    = !(vc < VP);
        p.col   = colour_fff ? 12'hFFF : 12'($urandom);
        p.fault = ((vc == stretch_v) && (hc == HT)) || ((vc == short_v) && (hc == HP - 1));

        vga.HS        = p.hs;
        vga.VS        = p.vs;
        vga.COLOUR_IN = p.col;
        RESET         = rst_v;

        e = '{default: 0};
        if (!rst_v) begin
            starts = 0;
            s1     = '{default: 0};
            prev   = '{default: 0};
        end else begin
            hs_fall = prev.hs && !s1.hs;
            vs_fall = prev.vs && !s1.vs;
            e.err   = s1.fault && (starts > 0);
            if (e.err) starts = 0;
            else if (hs_fall && vs_fall && starts < 2) starts++;
            e.locked = (starts == 2);
            e.valid  = e.locked && (s1.hc >= HP + HB) && (s1.hc < HP + HB + HD)
                                && (s1.vc >= VP + VB) && (s1.vc < VP + VB + VD);
            e.fs     = e.locked && hs_fall && vs_fall;
            e.x      = e.valid ? 10'(s1.hc - (HP + HB)) : 10'd0;
            e.y      = e.valid ? 10'(s1.vc - (VP + VB)) : 10'd0;
            e.col    = e.valid ? s1.col : 12'd0;
            prev = s1;
            s1   = p;
        end

        line_len = (vc == stretch_v) ? HT + 1 : HT;
        hc++;
        if (hc == line_len) begin
            hc = 0;
            if (vc == stretch_v) stretch_v = -1;
            if (vc == short_v) short_v = -1;
            vc = (vc + 1) % VT;
        end

        @(posedge CLK);
        #1;
        cyc++;
        chk("pixel_x",      vga.PIXEL_X,      e.x);
        chk("pixel_y",      vga.PIXEL_Y,      e.y);
        chk("pixel_colour", vga.PIXEL_COLOUR, e.col);
        chk("pixel_valid",  vga.PIXEL_VALID,  e.valid);
        chk("frame_start",  vga.FRAME_START,  e.fs);
        chk("locked",       vga.LOCKED,       e.locked);
        chk("timing_err",   vga.TIMING_ERR,   e.err);
        if (vga.LOCKED === 1'b1 && lock_rise_cyc < 0) lock_rise_cyc = cyc;
        if (vga.PIXEL_VALID === 1'b1) valid_cnt++;
        if (vga.TIMING_ERR === 1'b1) err_seen = 1'b1;
    endtask

    task automatic wait_fs();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2 * FRAME && !seen; i++) begin
            tick(1'b1);
            if (vga.FRAME_START === 1'b1) seen = 1'b1;
        end
        chk("frame_start_seen", seen, 1);
    endtask

    task automatic to_frame_start();
        for (int i = 0; i < FRAME + 2 && !(hc == 0 && vc == 0); i++) tick(1'b1);
    endtask

    initial begin
        int skip;
        s1   = '{default: 0};
        prev = '{default: 0};
        vga.HS = 1'b1;
        vga.VS = 1'b1;
        vga.COLOUR_IN = '0;

        // reset, then generator and decoder start together
        repeat (3) tick(1'b0);
        hc = 0;
        vc = 0;
        cyc = 0;
        lock_rise_cyc = -1;
        repeat (5 * FRAME) tick(1'b1);
        chk("lock_rise_cycle", lock_rise_cyc, 2 * FRAME + 2);
        chk("no_err_clean_run", err_seen, 0);

        wait_fs();
        valid_cnt = 0;
        repeat (FRAME) tick(1'b1);
        chk("valid_per_frame", valid_cnt, HD * VD);

        // one line stretched by a clock
        to_frame_start();
        stretch_v = $urandom_range(1, VT - 1);
        err_seen = 1'b0;
        repeat (FRAME + 4) tick(1'b1);
        chk("stretch_err_seen", err_seen, 1);
        repeat (2 * FRAME + 2) tick(1'b1);
        chk("relock_after_stretch", vga.LOCKED, 1);

        // one line with HS low one clock short
        to_frame_start();
        short_v = $urandom_range(0, VT - 1);
        err_seen = 1'b0;
        repeat (FRAME + 4) tick(1'b1);
        chk("short_hs_err_seen", err_seen, 1);
        repeat (2 * FRAME + 2) tick(1'b1);
        chk("relock_after_short_hs", vga.LOCKED, 1);

        // saturated colour: blanking must still read back as zero
        colour_fff = 1'b1;
        repeat (FRAME) tick(1'b1);
        colour_fff = 1'b0;

        // reset pulse in the middle of the active area while locked
        to_frame_start();
        skip = $urandom_range(VP + VB, VP + VB + VD - 1) * HT + $urandom_range(0, HT - 1);
        repeat (skip) tick(1'b1);
        repeat (3) tick(1'b0);
        chk("reset_drops_lock", vga.LOCKED, 0);
        repeat (FRAME) tick(1'b1);
        chk("no_lock_before_verify", vga.LOCKED, 0);
        repeat (FRAME + 4) tick(1'b1);
        chk("relock_after_reset", vga.LOCKED, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
